// File: rtl/inst_fifo.sv
// Dual-ported instruction buffer between fetch and dual-issue decode.
// Accepts up to two entries per cycle and shows the two oldest entries.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             write_en1,
    input  logic             write_en2,
    input  logic [31:0]      write_inst1,
    input  logic [31:0]      write_inst2,
    input  logic [31:0]      write_pc1,
    input  logic [31:0]      write_pc2,
    input  logic [2:0]       write_exc1,
    input  logic [2:0]       write_exc2,
    input  logic             read_en1,
    input  logic             read_en2,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic [31:0]      out_inst1,
    output logic [31:0]      out_inst2,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_pc2,
    output logic [2:0]       out_exc1,
    output logic [2:0]       out_exc2,
    output logic             fifo_full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  exc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_nx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             acc1, acc2, pop1, pop2;
    entry_t           head, head_nx;

    // Acceptance looks only at the registered count: a same-cycle pop frees nothing.
    always_comb begin
        acc1      = write_en1 && (count_q < CNT_W'(DEPTH));
        acc2      = write_en1 && write_en2 && (count_q < CNT_W'(DEPTH - 1));
        pop1      = read_en1 && (count_q != '0);
        pop2      = pop1 && read_en2 && (count_q > CNT_W'(1));
        wr_ptr_nx = wr_ptr_q + PTR_W'(1);
        rd_ptr_nx = rd_ptr_q + PTR_W'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(acc1) + PTR_W'(acc2);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop1) + PTR_W'(pop2);
            count_d  = count_q + CNT_W'(acc1) + CNT_W'(acc2)
                     - CNT_W'(pop1) - CNT_W'(pop2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (acc1) mem_q[wr_ptr_q]  <= '{inst: write_inst1, pc: write_pc1, exc: write_exc1};
            if (acc2) mem_q[wr_ptr_nx] <= '{inst: write_inst2, pc: write_pc2, exc: write_exc2};
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_nx    = mem_q[rd_ptr_nx];
        out_valid1 = (count_q != '0);
        out_valid2 = (count_q > CNT_W'(1));
        out_inst1  = out_valid1 ? head.inst    : '0;
        out_pc1    = out_valid1 ? head.pc      : '0;
        out_exc1   = out_valid1 ? head.exc     : '0;
        out_inst2  = out_valid2 ? head_nx.inst : '0;
        out_pc2    = out_valid2 ? head_nx.pc   : '0;
        out_exc2   = out_valid2 ? head_nx.exc  : '0;
        fifo_full  = (count_q > CNT_W'(DEPTH - 2));
        empty      = (count_q == '0);
        count      = count_q;
    end
endmodule

// File: tb/tb_inst_fifo.sv
// Randomized and directed bench for inst_fifo against a queue-based model.
module tb_inst_fifo;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 0, rst = 1, flush = 0;
    logic write_en1 = 0, write_en2 = 0, read_en1 = 0, read_en2 = 0;
    logic [31:0] write_inst1 = 0, write_inst2 = 0, write_pc1 = 0, write_pc2 = 0;
    logic [2:0]  write_exc1 = 0, write_exc2 = 0;
    logic out_valid1, out_valid2, fifo_full, empty;
    logic [31:0] out_inst1, out_inst2, out_pc1, out_pc2;
    logic [2:0]  out_exc1, out_exc2;
    logic [CNT_W-1:0] count;

    inst_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_inst1(write_inst1), .write_inst2(write_inst2),
        .write_pc1(write_pc1), .write_pc2(write_pc2),
        .write_exc1(write_exc1), .write_exc2(write_exc2),
        .read_en1(read_en1), .read_en2(read_en2),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_inst1(out_inst1), .out_inst2(out_inst2),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .out_exc1(out_exc1), .out_exc2(out_exc2),
        .fifo_full(fifo_full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    logic [66:0] q[$];   // {inst, pc, exc}, oldest first
    int errors = 0, checks = 0;
    logic [31:0] pc_ctr = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: decisions come from the occupancy before the edge.
    task automatic model_update();
        int n;
        bit a1, a2, p1, p2;
        if (rst || flush) begin
            q.delete();
            return;
        end
        n  = q.size();
        a1 = write_en1 && (n + 1 <= DEPTH);
        a2 = write_en1 && write_en2 && (n + 2 <= DEPTH);
        p1 = read_en1 && n >= 1;
        p2 = p1 && read_en2 && n >= 2;
        if (p1) void'(q.pop_front());
        if (p2) void'(q.pop_front());
        if (a1) q.push_back({write_inst1, write_pc1, write_exc1});
        if (a2) q.push_back({write_inst2, write_pc2, write_exc2});
    endtask

    task automatic compare_all();
        int n;
        logic [66:0] e1, e2;
        n  = q.size();
        e1 = (n >= 1) ? q[0] : '0;
        e2 = (n >= 2) ? q[1] : '0;
        chk("count", 32'(count), n);
        chk("empty", empty, n == 0);
        chk("fifo_full", fifo_full, (DEPTH - n) < 2);
        chk("out_valid1", out_valid1, n >= 1);
        chk("out_valid2", out_valid2, n >= 2);
        chk("out_inst1", out_inst1, e1[66:35]);
        chk("out_pc1", out_pc1, e1[34:3]);
        chk("out_exc1", 32'(out_exc1), 32'(e1[2:0]));
        chk("out_inst2", out_inst2, e2[66:35]);
        chk("out_pc2", out_pc2, e2[34:3]);
        chk("out_exc2", 32'(out_exc2), 32'(e2[2:0]));
    endtask

    // Called at a negedge: inputs stay stable across the next rising edge.
    task automatic drive(input bit we1, input bit we2, input bit re1, input bit re2,
                         input bit fl, input logic [2:0] x1, input logic [2:0] x2);
        write_en1 = we1; write_en2 = we2; read_en1 = re1; read_en2 = re2; flush = fl;
        write_inst1 = $urandom; write_inst2 = $urandom;
        write_pc1 = pc_ctr; write_pc2 = pc_ctr + 4;
        write_exc1 = x1; write_exc2 = x2;
        if (we1) pc_ctr += 8;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_valid1", out_valid1, 0);
        chk("rst_pc1", out_pc1, 0);
        cycle();
        cycle();
        rst = 0;

        // Two-wide push into an empty FIFO.
        pc_ctr = 32'hbfc00000;
        drive(1, 1, 0, 0, 0, 0, 0);
        write_inst1 = 32'h24010001; write_inst2 = 32'h24020002;
        cycle();
        chk("t1_pc1", out_pc1, 32'hbfc00000);
        chk("t1_pc2", out_pc2, 32'hbfc00004);
        chk("t1_inst1", out_inst1, 32'h24010001);
        chk("t1_count", 32'(count), 2);
        chk("t1_valid2", out_valid2, 1);

        // Fill to DEPTH; an extra write is dropped.
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        pc_ctr = 32'h1000;
        repeat (8) begin drive(1, 1, 0, 0, 0, $urandom_range(7), $urandom_range(7)); cycle(); end
        chk("t2_count", 32'(count), 16);
        chk("t2_full", fifo_full, 1);
        drive(1, 1, 0, 0, 0, 0, 0); cycle();
        chk("t2_count_drop", 32'(count), 16);
        chk("t2_head_pc", out_pc1, 32'h1000);

        // At count 15 only slot 1 fits despite the pop.
        drive(0, 0, 1, 0, 0, 0, 0); cycle();
        chk("t3_count15", 32'(count), 15);
        drive(1, 1, 1, 0, 0, 0, 0); cycle();
        chk("t3_count", 32'(count), 15);
        chk("t3_head_pc", out_pc1, 32'h1008);
        repeat (9) begin drive(0, 0, 1, 1, 0, 0, 0); cycle(); end
        chk("t3_drained", empty, 1);

        // Pointer wrap with sustained 2-in/2-out; popped pcs must be consecutive.
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        pc_ctr = 32'h2000; exp_pc = 32'h2000;
        drive(1, 1, 0, 0, 0, 0, 0); cycle();
        chk("t4_seq", out_pc1, exp_pc); exp_pc += 4;
        drive(1, 1, 1, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 32; i++) begin
            chk("t4_seq", out_pc1, exp_pc);
            chk("t4_seq", out_pc2, exp_pc + 4);
            exp_pc += 8;
            drive(1, 1, 1, 1, 0, $urandom_range(7), $urandom_range(7));
            cycle();
        end
        chk("t4_count", 32'(count), 3);

        // Two-wide read with a single entry pops just one.
        drive(0, 0, 0, 0, 1, 0, 0); cycle();
        drive(1, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 1, 1, 0, 0, 0); cycle();
        chk("t5_count", 32'(count), 0);
        chk("t5_empty", empty, 1);
        chk("t5_valid1", out_valid1, 0);
        chk("t5_inst1", out_inst1, 0);

        // Flush beats simultaneous reads and writes.
        repeat (3) begin drive(1, 1, 0, 0, 0, 0, 0); cycle(); end
        chk("t6_count6", 32'(count), 6);
        drive(1, 1, 1, 1, 1, 0, 0); cycle();
        chk("t6_count", 32'(count), 0);
        chk("t6_empty", empty, 1);
        drive(1, 0, 0, 0, 0, 3'b100, 0); cycle();
        chk("t6_exc1", 32'(out_exc1), 32'h4);
        chk("t6_valid1", out_valid1, 1);

        // Random traffic with rare flushes and one mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                drive(0, 0, 0, 0, 0, 0, 0);
                rst = 1;
                #1;
                chk("mid_rst_count", 32'(count), 0);
                chk("mid_rst_valid1", out_valid1, 0);
                chk("mid_rst_pc1", out_pc1, 0);
                cycle();
                rst = 0;
            end
            drive($urandom_range(3) != 0, $urandom_range(1) == 1,
                  (i < 100) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1),
                  $urandom_range(1) == 1, $urandom_range(31) == 0,
                  $urandom_range(7), $urandom_range(7));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
